// File: rtl/hs32_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hs32_sram_arbiter
// Function : Round-robin arbiter of Wishbone and hs32 core onto banked SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module hs32_sram_arbiter #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          NBANK_LOG2 = 2
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_we_i,
    input  logic [3:0]                    wbs_sel_i,
    input  logic [31:0]                   wbs_adr_i,
    input  logic [31:0]                   wbs_dat_i,
    output logic                          wbs_ack_o,
    output logic [31:0]                   wbs_dat_o,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [NBANK_LOG2+7:0]         cpu_addr,
    input  logic [3:0]                    cpu_mask,
    input  logic [31:0]                   cpu_wdata,
    output logic                          cpu_gnt,
    output logic                          cpu_rvalid,
    output logic [31:0]                   cpu_rdata,
    output logic [(1<<NBANK_LOG2)-1:0]    sram_csb,
    output logic                          sram_web,
    output logic [3:0]                    sram_wmask,
    output logic [7:0]                    sram_addr,
    output logic [31:0]                   sram_din,
    input  logic [(32<<NBANK_LOG2)-1:0]   sram_dout
);

    localparam int c_nbank = 1 << NBANK_LOG2;
    localparam int c_bank_hi = NBANK_LOG2 + 9;
    localparam logic [c_nbank-1:0] c_one = {{(c_nbank-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_last_cpu;
    logic                    r_owner_cpu;
    logic                    r_we;
    logic [NBANK_LOG2-1:0]   r_bank;

    logic                    w_wb_req;
    logic                    w_in_range;
    logic                    w_wb_win;
    logic                    w_cpu_win;
    logic [NBANK_LOG2-1:0]   w_cmd_bank;
    logic                    w_cmd_we;
    logic [3:0]              w_cmd_mask;
    logic [7:0]              w_cmd_addr;
    logic [31:0]             w_cmd_din;
    logic [31:0]             w_rd_word;
    logic                    w_unused;

    assign w_wb_req   = wbs_cyc_i & wbs_stb_i;
    assign w_in_range = (wbs_adr_i[31:c_bank_hi+1] == BASE_ADDR[31:c_bank_hi+1]);

    // On a tie the master that did not win last time is served.
    assign w_wb_win  = w_wb_req & (~cpu_req | r_last_cpu);
    assign w_cpu_win = cpu_req & (~w_wb_req | ~r_last_cpu);
    assign cpu_gnt   = (r_state == ST_IDLE) & w_cpu_win;

    assign w_cmd_bank = w_wb_win ? wbs_adr_i[c_bank_hi:10] : cpu_addr[NBANK_LOG2+7:8];
    assign w_cmd_we   = w_wb_win ? wbs_we_i : cpu_we;
    assign w_cmd_mask = w_wb_win ? wbs_sel_i : cpu_mask;
    assign w_cmd_addr = w_wb_win ? wbs_adr_i[9:2] : cpu_addr[7:0];
    assign w_cmd_din  = w_wb_win ? wbs_dat_i : cpu_wdata;

    assign w_rd_word = sram_dout[{r_bank, 5'b0} +: 32];
    assign w_unused  = &{1'b0, wbs_adr_i[1:0]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_last_cpu  <= 1'b0;
            r_owner_cpu <= 1'b0;
            r_we        <= 1'b0;
            r_bank      <= '0;
            sram_csb    <= '1;
            sram_web    <= 1'b1;
            sram_wmask  <= 4'h0;
            sram_addr   <= 8'h00;
            sram_din    <= 32'h0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= 32'h0;
            cpu_rvalid  <= 1'b0;
            cpu_rdata   <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wb_win && !w_in_range) begin
                        // Outside the window: answer at once, never touch the macros.
                        r_last_cpu  <= 1'b0;
                        r_owner_cpu <= 1'b0;
                        r_we        <= wbs_we_i;
                        wbs_ack_o   <= 1'b1;
                        if (!wbs_we_i) begin
                            wbs_dat_o <= 32'h0;
                        end
                        r_state     <= ST_RESP;
                    end else if (w_wb_win || w_cpu_win) begin
                        r_last_cpu  <= w_cpu_win & ~w_wb_win;
                        r_owner_cpu <= w_cpu_win & ~w_wb_win;
                        r_we        <= w_cmd_we;
                        r_bank      <= w_cmd_bank;
                        sram_csb    <= ~(c_one << w_cmd_bank);
                        sram_web    <= ~w_cmd_we;
                        sram_wmask  <= w_cmd_we ? w_cmd_mask : 4'h0;
                        sram_addr   <= w_cmd_addr;
                        sram_din    <= w_cmd_din;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    sram_csb <= '1;
                    sram_web <= 1'b1;
                    if (r_we) begin
                        wbs_ack_o <= ~r_owner_cpu;
                        r_state   <= ST_RESP;
                    end else begin
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_owner_cpu) begin
                        cpu_rdata  <= w_rd_word;
                        cpu_rvalid <= 1'b1;
                    end else begin
                        wbs_dat_o  <= w_rd_word;
                        wbs_ack_o  <= 1'b1;
                    end
                    r_state <= ST_RESP;
                end
                default: begin
                    wbs_ack_o  <= 1'b0;
                    cpu_rvalid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hs32_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs32_sram_arbiter
// Function : Directed and random bench with a transaction-schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hs32_sram_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         cyc, stb, we;
    logic [3:0]   sel;
    logic [31:0]  adr, wdat;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic         cpu_req, cpu_we;
    logic [9:0]   cpu_addr;
    logic [3:0]   cpu_mask;
    logic [31:0]  cpu_wdata;
    logic         cpu_gnt, cpu_rvalid;
    logic [31:0]  cpu_rdata;
    logic [3:0]   sram_csb;
    logic         sram_web;
    logic [3:0]   sram_wmask;
    logic [7:0]   sram_addr;
    logic [31:0]  sram_din;
    logic [127:0] sram_dout;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    hs32_sram_arbiter #(.BASE_ADDR(32'h3000_0000), .NBANK_LOG2(2)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_mask(cpu_mask),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // Four single-port macros: command sampled on the edge, read data one cycle later.
    logic [31:0] sram_mem [0:1023];
    logic [31:0] sram_q   [0:3];
    logic [31:0] ref_mem  [0:1023];
    assign sram_dout = {sram_q[3], sram_q[2], sram_q[1], sram_q[0]};

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!sram_csb[k]) begin
                if (!sram_web) begin
                    for (int b = 0; b < 4; b++)
                        if (sram_wmask[b]) sram_mem[k*256 + sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
                end else begin
                    sram_q[k] <= sram_mem[k*256 + sram_addr];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: each grant schedules the cycles at which its effects must appear.
    initial begin : model
        int t, free_at, cmd_at, ack_at, rv_at, idx;
        logic wq, gw, gc, ack_rd, m_last_cpu;
        logic [3:0] e_csb, e_wmask;
        logic e_web;
        logic [7:0] e_addr;
        logic [31:0] e_din, e_ack_dat, e_rv_dat, m_wb_dat, m_cpu_dat, w;
        @(posedge clk);
        t = 0; free_at = 0; cmd_at = -1; ack_at = -1; rv_at = -1;
        ack_rd = 0; m_last_cpu = 0; m_wb_dat = 0; m_cpu_dat = 0;
        e_csb = 4'hF; e_web = 1; e_wmask = 0; e_addr = 0; e_din = 0; e_ack_dat = 0; e_rv_dat = 0;
        forever begin
            @(negedge clk);
            if (t == ack_at && ack_rd) m_wb_dat = e_ack_dat;
            if (t == rv_at) m_cpu_dat = e_rv_dat;
            chk("csb", {28'h0, sram_csb}, (t == cmd_at) ? {28'h0, e_csb} : 32'hF);
            chk("web", {31'h0, sram_web}, (t == cmd_at) ? {31'h0, e_web} : 32'h1);
            if (t == cmd_at) begin
                chk("wmask", {28'h0, sram_wmask}, {28'h0, e_wmask});
                chk("addr", {24'h0, sram_addr}, {24'h0, e_addr});
                chk("din", sram_din, e_din);
            end
            chk("ack", {31'h0, wbs_ack_o}, {31'h0, t == ack_at});
            chk("rvalid", {31'h0, cpu_rvalid}, {31'h0, t == rv_at});
            chk("wb_dat", wbs_dat_o, m_wb_dat);
            chk("cpu_rdata", cpu_rdata, m_cpu_dat);
            wq = cyc & stb;
            gw = 0; gc = 0;
            if (t >= free_at) begin
                if (wq && cpu_req) begin
                    gw = m_last_cpu; gc = ~m_last_cpu;
                end else begin
                    gw = wq; gc = cpu_req;
                end
            end
            chk("cpu_gnt", {31'h0, cpu_gnt}, {31'h0, gc});
            if (rst) begin
                free_at = t + 1; cmd_at = -1; ack_at = -1; rv_at = -1;
                m_last_cpu = 0; m_wb_dat = 0; m_cpu_dat = 0;
            end else if (gw && adr[31:12] != 20'h30000) begin
                m_last_cpu = 0; ack_at = t + 1; ack_rd = ~we; e_ack_dat = 0; free_at = t + 2;
            end else if (gw || gc) begin
                m_last_cpu = gc;
                idx = gw ? int'(adr[11:2]) : int'(cpu_addr);
                e_csb = ~(4'b0001 << idx[9:8]);
                e_web = gw ? ~we : ~cpu_we;
                e_wmask = (gw ? we : cpu_we) ? (gw ? sel : cpu_mask) : 4'h0;
                e_addr = idx[7:0];
                e_din = gw ? wdat : cpu_wdata;
                cmd_at = t + 1;
                if (!e_web) begin
                    w = ref_mem[idx];
                    for (int b = 0; b < 4; b++) if (e_wmask[b]) w[8*b +: 8] = e_din[8*b +: 8];
                    ref_mem[idx] = w;
                    if (gw) begin ack_at = t + 2; ack_rd = 0; end
                    free_at = t + 3;
                end else begin
                    if (gw) begin ack_at = t + 3; ack_rd = 1; e_ack_dat = ref_mem[idx]; end
                    else begin rv_at = t + 3; e_rv_dat = ref_mem[idx]; end
                    free_at = t + 4;
                end
            end
            t++;
        end
    end

    task automatic wb_op(input logic w_e, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                         output int lat, output logic [31:0] rd, output logic [3:0] icsb,
                         output logic [7:0] iaddr, output logic [3:0] imask, output logic cs_seen);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w_e; adr = a; sel = s; wdat = d;
        lat = -1; rd = 0; icsb = 4'hF; iaddr = 0; imask = 0; cs_seen = 0;
        for (int k = 0; k < 12 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin icsb = sram_csb; iaddr = sram_addr; imask = sram_wmask; end
            if (sram_csb != 4'hF) cs_seen = 1;
            if (wbs_ack_o) begin lat = k; rd = wbs_dat_o; end
        end
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic cpu_op(input logic w_e, input logic [9:0] a, input logic [31:0] d,
                          output int gk, output int lat, output logic [31:0] rd,
                          output logic [3:0] icsb, output int nrv);
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = w_e; cpu_addr = a; cpu_mask = 4'hF; cpu_wdata = d;
        gk = -1; lat = -1; rd = 0; icsb = 4'hF; nrv = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (gk < 0 && cpu_gnt) gk = k;
            if (gk >= 0 && k == gk + 1) icsb = sram_csb;
            if (cpu_rvalid) begin nrv++; lat = k - gk; rd = cpu_rdata; end
            @(posedge clk); #1;
            if (gk >= 0) cpu_req = 0;
        end
        cpu_req = 0; cpu_we = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1);
    end

    initial begin : stim
        int lat, gk, nrv, nev;
        logic [31:0] rd;
        logic [3:0] icsb, imask, seq;
        logic [7:0] iaddr;
        logic cs_seen, s_ack, s_gnt, wb_pend, cpu_pend;
        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = $urandom;
            ref_mem[i] = sram_mem[i];
        end
        for (int k = 0; k < 4; k++) sram_q[k] = 32'h0;
        rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_mask = 0; cpu_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_csb", {28'h0, sram_csb}, 32'hF);
        chk("rst_web", {31'h0, sram_web}, 32'h1);
        chk("rst_wmask", {28'h0, sram_wmask}, 32'h0);
        chk("rst_addr", {24'h0, sram_addr}, 32'h0);
        chk("rst_din", sram_din, 32'h0);
        chk("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        chk("rst_wbdat", wbs_dat_o, 32'h0);
        chk("rst_rvalid", {31'h0, cpu_rvalid}, 32'h0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        @(posedge clk); #1 rst = 0;

        // Full-word write then readback; 0x404 decodes to bank 1, word 1.
        wb_op(1, 32'h3000_0404, 4'hF, 32'hDEADBEEF, lat, rd, icsb, iaddr, imask, cs_seen);
        chk("wr_lat", lat, 2);
        chk("wr_csb", {28'h0, icsb}, 32'hD);
        chk("wr_addr", {24'h0, iaddr}, 32'h01);
        chk("wr_wmask", {28'h0, imask}, 32'hF);
        wb_op(0, 32'h3000_0404, 4'hF, 32'h0, lat, rd, icsb, iaddr, imask, cs_seen);
        chk("rd_lat", lat, 3);
        chk("rd_data", rd, 32'hDEADBEEF);

        wb_op(1, 32'h3000_0808, 4'hF, 32'h11223344, lat, rd, icsb, iaddr, imask, cs_seen);
        wb_op(1, 32'h3000_0808, 4'b0010, 32'h0000AA00, lat, rd, icsb, iaddr, imask, cs_seen);
        chk("byte_wmask", {28'h0, imask}, 32'h2);
        wb_op(0, 32'h3000_0808, 4'hF, 32'h0, lat, rd, icsb, iaddr, imask, cs_seen);
        chk("byte_data", rd, 32'h1122AA44);

        cpu_op(1, 10'h3FF, 32'h12345678, gk, lat, rd, icsb, nrv);
        chk("cpuw_gnt", gk, 0);
        chk("cpuw_csb", {28'h0, icsb}, 32'h7);
        chk("cpuw_norv", nrv, 0);
        cpu_op(0, 10'h3FF, 32'h0, gk, lat, rd, icsb, nrv);
        chk("cpur_gnt", gk, 0);
        chk("cpur_lat", lat, 3);
        chk("cpur_data", rd, 32'h12345678);

        wb_op(0, 32'h3000_1000, 4'hF, 32'h0, lat, rd, icsb, iaddr, imask, cs_seen);
        chk("oor_lat", lat, 1);
        chk("oor_data", rd, 32'h0);
        chk("oor_cs", {31'h0, cs_seen}, 32'h0);

        // Strobe withdrawn after the grant cycle: the access still finishes.
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = 32'h3000_0404;
        @(negedge clk);
        @(posedge clk); #1 cyc = 0; stb = 0;
        lat = -1;
        for (int k = 1; k < 9; k++) begin
            @(negedge clk);
            if (wbs_ack_o && lat < 0) begin lat = k; rd = wbs_dat_o; end
        end
        chk("abort_lat", lat, 3);
        chk("abort_data", rd, 32'hDEADBEEF);

        // Reset during the read-data cycle kills the ack.
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = 32'h3000_0404;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1; cyc = 0; stb = 0;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rstw_csb", {28'h0, sram_csb}, 32'hF);
        chk("rstw_web", {31'h0, sram_web}, 32'h1);
        chk("rstw_ack", {31'h0, wbs_ack_o}, 32'h0);
        wb_op(0, 32'h3000_0404, 4'hF, 32'h0, lat, rd, icsb, iaddr, imask, cs_seen);
        chk("rstw_lat", lat, 3);
        chk("rstw_data", rd, 32'hDEADBEEF);

        // Both masters reading continuously from reset: CPU first, then alternation.
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        cyc = 1; stb = 1; we = 0; adr = 32'h3000_0404;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h3FF;
        seq = 0; nev = 0;
        for (int k = 0; k < 30 && nev < 4; k++) begin
            @(negedge clk);
            if (cpu_rvalid) begin seq = {seq[2:0], 1'b1}; nev++; end
            if (wbs_ack_o) begin seq = {seq[2:0], 1'b0}; nev++; end
        end
        @(posedge clk); #1 cyc = 0; stb = 0; cpu_req = 0;
        chk("alt_count", nev, 4);
        chk("alt_order", {28'h0, seq}, 32'hA);
        repeat (4) @(posedge clk);

        wb_pend = 0; cpu_pend = 0;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            s_ack = wbs_ack_o; s_gnt = cpu_gnt;
            @(posedge clk); #1;
            rst = 0;
            if (wb_pend && s_ack) begin cyc = 0; stb = 0; wb_pend = 0; end
            if (cpu_pend && s_gnt) begin cpu_req = 0; cpu_pend = 0; end
            if ($urandom_range(0, 399) == 0) begin
                rst = 1; cyc = 0; stb = 0; cpu_req = 0; wb_pend = 0; cpu_pend = 0;
            end else begin
                if (!wb_pend && $urandom_range(0, 2) == 0) begin
                    wb_pend = 1; cyc = 1; stb = 1; we = 1'($urandom_range(0, 1));
                    sel = 4'($urandom); wdat = $urandom;
                    adr = 32'h3000_0000 | ($urandom_range(0, 3) << 10)
                        | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
                    if ($urandom_range(0, 9) == 0) adr = adr ^ 32'h0000_1000;
                    else if ($urandom_range(0, 19) == 0) adr = adr ^ 32'h1000_0000;
                end
                if (!cpu_pend && $urandom_range(0, 2) == 0) begin
                    cpu_pend = 1; cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
                    cpu_mask = 4'($urandom); cpu_wdata = $urandom;
                    cpu_addr = 10'(($urandom_range(0, 3) << 8) | $urandom_range(0, 7));
                end
            end
        end
        @(posedge clk); #1;
        rst = 0; cyc = 0; stb = 0; cpu_req = 0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
